// File: rtl/condicionador_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : condicionador_pkg
// Description : Shared definitions for the button conditioning stage:
//               FSM state codes, default debounce length and a small
//               population-count helper for the 4-bit button vector.
// Revision    : 1.0 - initial release
// ============================================================================
package condicionador_pkg;

    // 1 ms at 50 MHz
    localparam int C_DEBOUNCE_CYCLES_PADRAO = 50000;

    // State codes are exposed on db_estado, so their values are fixed.
    typedef enum logic [3:0] {
        OCIOSO      = 4'd0,
        PRESSIONADO = 4'd1,
        INVALIDO    = 4'd2
    } estado_t;

    // Number of buttons set in a 4-bit vector (0..4).
    function automatic logic [2:0] conta_bits(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : debounce_bit
// Description : Two-flop synchronizer followed by a counter-based debouncer
//               for one raw asynchronous input.
// Ports       : clock   - system clock (rising edge)
//               reset   - synchronous, active-high
//               bruto   - raw asynchronous input
//               estavel - debounced level
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit
    import condicionador_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES_PADRAO,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic bruto,
    output logic estavel
);

    localparam logic [CNT_WIDTH-1:0] c_limite = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_um     = CNT_WIDTH'(1);

    logic                 r_sinc1;
    logic                 r_sinc2;
    logic [CNT_WIDTH-1:0] r_cont;
    logic                 r_estavel;

    // The counter holds how many consecutive edges the synchronized value
    // has disagreed with the accepted level; reaching DEBOUNCE_CYCLES
    // disagreements accepts the new level.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sinc1   <= 1'b0;
            r_sinc2   <= 1'b0;
            r_cont    <= '0;
            r_estavel <= 1'b0;
        end else begin
            r_sinc1 <= bruto;
            r_sinc2 <= r_sinc1;
            if (r_sinc2 != r_estavel) begin
                if (r_cont == c_limite) begin
                    r_estavel <= r_sinc2;
                    r_cont    <= '0;
                end else begin
                    r_cont <= r_cont + c_um;
                end
            end else begin
                r_cont <= '0;
            end
        end
    end

    assign estavel = r_estavel;

endmodule
`default_nettype wire

// File: rtl/condicionador_botoes.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : condicionador_botoes
// Description : Input conditioning for the game top level. Synchronizes and
//               debounces botoes[3:0] and jogar, emits one single-cycle
//               jogada pulse per valid single-button press (with its one-hot
//               code) and a single-cycle pulse on each jogar press.
// Ports       : clock, reset (sync, active-high)
//               botoes[3:0], jogar         - raw asynchronous inputs
//               botoes_estaveis[3:0]       - debounced button levels
//               jogada_pulso, jogada_codigo[3:0]
//               jogar_pulso
//               erro_multiplo              - multi-button press pulse
//               db_estado[3:0]             - FSM state code
// Build option: CONDICIONADOR_ERRO_MULTIPLO_EN enables erro_multiplo;
//               otherwise the port is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module condicionador_botoes
    import condicionador_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES_PADRAO,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       jogar,
    output logic [3:0] botoes_estaveis,
    output logic       jogada_pulso,
    output logic [3:0] jogada_codigo,
    output logic       jogar_pulso,
    output logic       erro_multiplo,
    output logic [3:0] db_estado
);

    logic [3:0] w_estaveis;
    logic       w_jogar_estavel;
    logic [2:0] w_qtd;

    estado_t    r_estado;
    estado_t    w_prox_estado;
    logic       w_jogada_pulso;
    logic [3:0] w_codigo;

    logic       r_jogada_pulso;
    logic [3:0] r_codigo;
    logic       r_jogar_ant;
    logic       r_jogar_pulso;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_botoes
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_WIDTH       (CNT_WIDTH)
            ) u_db (
                .clock   (clock),
                .reset   (reset),
                .bruto   (botoes[gi]),
                .estavel (w_estaveis[gi])
            );
        end
    endgenerate

    debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_db_jogar (
        .clock   (clock),
        .reset   (reset),
        .bruto   (jogar),
        .estavel (w_jogar_estavel)
    );

    assign w_qtd = conta_bits(w_estaveis);

    // Only a press seen from OCIOSO can produce a pulse, so holding a button
    // (or adding more buttons while held) never repeats it.
    always_comb begin
        w_prox_estado  = r_estado;
        w_jogada_pulso = 1'b0;
        w_codigo       = r_codigo;
        case (r_estado)
            OCIOSO: begin
                if (w_qtd == 3'd1) begin
                    w_jogada_pulso = 1'b1;
                    w_codigo       = w_estaveis;
                    w_prox_estado  = PRESSIONADO;
                end else if (w_qtd != 3'd0) begin
                    w_prox_estado  = INVALIDO;
                end
            end
            PRESSIONADO, INVALIDO: begin
                if (w_estaveis == 4'd0) begin
                    w_prox_estado = OCIOSO;
                end
            end
            default: w_prox_estado = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado       <= OCIOSO;
            r_jogada_pulso <= 1'b0;
            r_codigo       <= 4'd0;
            r_jogar_ant    <= 1'b0;
            r_jogar_pulso  <= 1'b0;
        end else begin
            r_estado       <= w_prox_estado;
            r_jogada_pulso <= w_jogada_pulso;
            r_codigo       <= w_codigo;
            r_jogar_ant    <= w_jogar_estavel;
            r_jogar_pulso  <= w_jogar_estavel & ~r_jogar_ant;
        end
    end

`ifdef CONDICIONADOR_ERRO_MULTIPLO_EN
    logic w_erro;
    logic r_erro;

    // Same condition as the OCIOSO -> INVALIDO transition.
    assign w_erro = (r_estado == OCIOSO) && (w_qtd >= 3'd2);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_erro <= 1'b0;
        end else begin
            r_erro <= w_erro;
        end
    end

    assign erro_multiplo = r_erro;
`else
    assign erro_multiplo = 1'b0;
`endif

    assign botoes_estaveis = w_estaveis;
    assign jogada_pulso    = r_jogada_pulso;
    assign jogada_codigo   = r_codigo;
    assign jogar_pulso     = r_jogar_pulso;
    assign db_estado       = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_condicionador_botoes.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_condicionador_botoes
// Description : Self-checking bench for condicionador_botoes with
//               DEBOUNCE_CYCLES = 4. A behavioural model predicts every
//               output on every cycle from the raw input history.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_condicionador_botoes;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] botoes;
    logic       jogar;
    logic [3:0] botoes_estaveis;
    logic       jogada_pulso;
    logic [3:0] jogada_codigo;
    logic       jogar_pulso;
    logic       erro_multiplo;
    logic [3:0] db_estado;

    always #5 clock = ~clock;

    condicionador_botoes #(.DEBOUNCE_CYCLES(D)) dut (
        .clock           (clock),
        .reset           (reset),
        .botoes          (botoes),
        .jogar           (jogar),
        .botoes_estaveis (botoes_estaveis),
        .jogada_pulso    (jogada_pulso),
        .jogada_codigo   (jogada_codigo),
        .jogar_pulso     (jogar_pulso),
        .erro_multiplo   (erro_multiplo),
        .db_estado       (db_estado)
    );

    int n_assert = 0;
    int n_falhas = 0;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_assert++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, obs, esp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Raw inputs sampled at rising edge k are hist[k] = {jogar, botoes}.
    // The debouncer sees, at edge n, the raw value of edge n-2; a level is
    // accepted at edge n when the D samples of edges n-1-D .. n-2 all
    // disagree with the current stable level. Samples at or before a reset
    // edge count as 0 because reset clears the synchronizer.
    logic [4:0] hist [0:8191];
    int         n_borda   = 0;
    int         ult_reset = -100;
    logic [4:0] m_est     = '0;
    int         m_q       = 0;   // 0 idle, 1 pressed, 2 invalid
    logic       m_jp      = 1'b0;
    logic       m_jogp    = 1'b0;
    logic       m_erro    = 1'b0;
    logic [3:0] m_cod     = '0;
    logic       m_j_ant   = 1'b0;

    function automatic logic [4:0] efetivo(input int k);
        if (k < 1 || k <= ult_reset) return 5'd0;
        return hist[k];
    endfunction

    task automatic modelo_borda(input logic r);
        int         pop;
        logic       muda;
        logic [4:0] amostra;
        if (r) begin
            m_est = '0; m_q = 0; m_jp = 0; m_jogp = 0; m_erro = 0;
            m_cod = '0; m_j_ant = 0; ult_reset = n_borda;
        end else begin
            pop    = $countones(m_est[3:0]);
            m_jp   = (m_q == 0) && (pop == 1);
            if (m_jp) m_cod = m_est[3:0];
`ifdef CONDICIONADOR_ERRO_MULTIPLO_EN
            m_erro = (m_q == 0) && (pop >= 2);
`else
            m_erro = 1'b0;
`endif
            m_jogp  = m_est[4] & ~m_j_ant;
            m_j_ant = m_est[4];
            if (m_q == 0) begin
                if (pop == 1) m_q = 1;
                else if (pop >= 2) m_q = 2;
            end else if (m_est[3:0] == 4'd0) begin
                m_q = 0;
            end
            for (int b = 0; b < 5; b++) begin
                muda = 1'b1;
                for (int k = n_borda - 1 - D; k <= n_borda - 2; k++) begin
                    amostra = efetivo(k);
                    if (amostra[b] == m_est[b]) muda = 1'b0;
                end
                if (muda) m_est[b] = ~m_est[b];
            end
        end
    endtask

    int cnt_jp   = 0;
    int cnt_jogp = 0;
    int cnt_erro = 0;

    // One clock cycle: drive, clock edge, model update, compare at negedge.
    task automatic ciclo(input logic [3:0] b, input logic j, input logic r);
        botoes = b; jogar = j; reset = r;
        @(posedge clock);
        n_borda++;
        hist[n_borda] = {j, b};
        modelo_borda(r);
        @(negedge clock);
        verifica("botoes_estaveis", 32'(botoes_estaveis), 32'(m_est[3:0]));
        verifica("jogada_pulso",    32'(jogada_pulso),    32'(m_jp));
        verifica("jogada_codigo",   32'(jogada_codigo),   32'(m_cod));
        verifica("jogar_pulso",     32'(jogar_pulso),     32'(m_jogp));
        verifica("erro_multiplo",   32'(erro_multiplo),   32'(m_erro));
        verifica("db_estado",       32'(db_estado),       32'(m_q));
        if (jogada_pulso)  cnt_jp++;
        if (jogar_pulso)   cnt_jogp++;
        if (erro_multiplo) cnt_erro++;
    endtask

    task automatic segura(input logic [3:0] b, input logic j, input int n);
        for (int i = 0; i < n; i++) ciclo(b, j, 1'b0);
    endtask

    task automatic zera_contagens();
        cnt_jp = 0; cnt_jogp = 0; cnt_erro = 0;
    endtask

    int esp_erro;

    initial begin
        botoes = '0; jogar = 1'b0; reset = 1'b1;
`ifdef CONDICIONADOR_ERRO_MULTIPLO_EN
        esp_erro = 1;
`else
        esp_erro = 0;
`endif
        ciclo(4'd0, 1'b0, 1'b1);
        ciclo(4'd0, 1'b0, 1'b1);
        verifica("reset_estado", 32'(db_estado), 32'd0);
        segura(4'd0, 1'b0, 3);

        // Clean single press: pulse after edge 7 of the press.
        zera_contagens();
        segura(4'b0010, 1'b0, 6);
        verifica("press_sem_pulso_cedo", 32'(cnt_jp), 32'd0);
        segura(4'b0010, 1'b0, 1);
        verifica("press_pulso_borda7", 32'(jogada_pulso), 32'd1);
        segura(4'b0010, 1'b0, 13);
        segura(4'b0000, 1'b0, 12);
        verifica("press_pulsos", 32'(cnt_jp), 32'd1);
        verifica("press_codigo_retido", 32'(jogada_codigo), 32'b0010);

        // Bounce on bit 0, then steady.
        zera_contagens();
        for (int i = 0; i < 4; i++) segura({3'b000, ~i[0]}, 1'b0, 2);
        segura(4'b0001, 1'b0, 10);
        segura(4'b0000, 1'b0, 12);
        verifica("bounce_pulsos", 32'(cnt_jp), 32'd1);

        // Multi-press.
        zera_contagens();
        segura(4'b0101, 1'b0, 10);
        verifica("multi_estado", 32'(db_estado), 32'd2);
        segura(4'b0000, 1'b0, 12);
        verifica("multi_pulsos", 32'(cnt_jp), 32'd0);
        verifica("multi_erro", 32'(cnt_erro), 32'(esp_erro));
        verifica("multi_volta_ocioso", 32'(db_estado), 32'd0);

        // Hold plus extra button.
        zera_contagens();
        segura(4'b1000, 1'b0, 10);
        segura(4'b1001, 1'b0, 10);
        segura(4'b0001, 1'b0, 10);
        verifica("extra_ainda_press", 32'(db_estado), 32'd1);
        segura(4'b0000, 1'b0, 12);
        verifica("extra_pulsos", 32'(cnt_jp), 32'd1);
        verifica("extra_codigo", 32'(jogada_codigo), 32'b1000);

        // Jogar.
        zera_contagens();
        segura(4'b0000, 1'b1, 15);
        segura(4'b0000, 1'b0, 12);
        verifica("jogar_pulsos", 32'(cnt_jogp), 32'd1);

        // Reset mid-press.
        zera_contagens();
        segura(4'b0100, 1'b0, 10);
        ciclo(4'b0100, 1'b0, 1'b1);
        verifica("reset_meio_estaveis", 32'(botoes_estaveis), 32'd0);
        verifica("reset_meio_codigo", 32'(jogada_codigo), 32'd0);
        verifica("reset_meio_estado", 32'(db_estado), 32'd0);
        zera_contagens();
        segura(4'b0100, 1'b0, 7);
        verifica("reset_meio_pulso", 32'(jogada_pulso), 32'd1);
        segura(4'b0100, 1'b0, 5);
        segura(4'b0000, 1'b0, 12);
        verifica("reset_meio_pulsos", 32'(cnt_jp), 32'd1);

        // Randomized segments, including short glitches and occasional reset.
        for (int s = 0; s < 300; s++) begin
            logic [3:0] vb;
            logic       vj;
            int         len;
            vb  = 4'($urandom);
            if ($urandom_range(0, 2) == 0) vb = 4'd1 << $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) vb = 4'd0;
            vj  = 1'($urandom);
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 39) == 0) ciclo(vb, vj, 1'b1);
            segura(vb, vj, len);
        end
        segura(4'd0, 1'b0, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_falhas);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/condicionador_botoes.md
Name: condicionador_botoes

Overview:
- Input conditioning stage placed directly upstream of the game top level (FD/UC pair). Takes the raw `botoes[3:0]` and `jogar` pins.
- Synchronizes and debounces every input.
- Emits one clean single-cycle `jogada` pulse per valid press, with the one-hot code of the pressed button, plus a single-cycle `jogar` pulse.
- Its outputs replace the raw pins that feed the data path and control unit.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a level change is accepted (1 ms at 50 MHz).
- CNT_WIDTH, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived; do not override).

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- botoes  in  4  raw asynchronous buttons, active-high
- jogar  in  1  raw asynchronous start button, active-high
- botoes_estaveis  out  4  debounced button levels
- jogada_pulso  out  1  one-cycle pulse on valid single-button press
- jogada_codigo  out  4  one-hot code of last valid press, held until next valid press
- jogar_pulso  out  1  one-cycle pulse on debounced rising edge of jogar
- erro_multiplo  out  1  one-cycle pulse on multi-button press (see Optional Feature)
- db_estado  out  4  FSM state code for hexa7seg display

Behaviour:
- Interface (already decided): one clock, `clock`; reset is synchronous and active-high, named `reset`.
- Reset (synchronous): all sync flops, stable levels, counters and outputs go to 0. FSM goes to OCIOSO. `jogada_codigo` is 0.
- Synchronization: each of the 5 raw inputs passes through a 2-flop synchronizer.
- Debounce, per bit:
  - Counter increments on each edge where the synchronized value differs from the stable value; it clears to 0 on any edge where they match.
  - When the counter would reach DEBOUNCE_CYCLES, the stable value takes the synchronized value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the stable value.
- Latency: a raw level held from rising edge 1 changes the stable value at edge DEBOUNCE_CYCLES+2. Registered pulses (`jogada_pulso`, `jogar_pulso`) are high for exactly the cycle following edge DEBOUNCE_CYCLES+3.
- FSM (on `botoes_estaveis`):
  - OCIOSO (code 0):
    - Stable vector == 0: stay.
    - Exactly one bit set: assert `jogada_pulso` for one cycle, load `jogada_codigo`, go to PRESSIONADO.
    - Two or more bits set: go to INVALIDO with no `jogada_pulso`.
  - PRESSIONADO (code 1): wait until stable vector == 0, then go to OCIOSO. Extra buttons pressed meanwhile are ignored; no second pulse.
  - INVALIDO (code 2): wait until stable vector == 0, then go to OCIOSO.
  - Codes 3–15 are unused; any of them goes to OCIOSO.
- Auto-repeat: none. Holding a button indefinitely produces exactly one pulse.
- `jogar_pulso`: produced from the stable-jogar rising edge only; it is independent of the FSM and may coincide with `jogada_pulso`.
- Reset mid-press: the stable value returns to 0. If the button is still held after reset deasserts, it re-debounces and produces one new pulse after the full latency.
- Simultaneous press: two buttons whose stable values rise on the same edge count as a multi-press and go to INVALIDO.

Optional Feature:
- Macro: CONDICIONADOR_ERRO_MULTIPLO_EN.
- Defined: the OCIOSO→INVALIDO transition drives `erro_multiplo` high for one cycle.
- Undefined: `erro_multiplo` is tied to 0. The port is always present, and the FSM behaviour is otherwise identical.

Decomposition:
- Shared package `condicionador_pkg` holds:
  - state encodings OCIOSO=4'd0, PRESSIONADO=4'd1, INVALIDO=4'd2;
  - the default DEBOUNCE_CYCLES constant.
- One sub-module, `debounce_bit`: 2-flop synchronizer plus counter plus stable register, parameterized by DEBOUNCE_CYCLES. Instantiate 5 times (4 botoes + jogar).
- FSM and edge detection live in the top module.

Test Plan (DEBOUNCE_CYCLES=4 in simulation):
- Clean single press: botoes=4'b0010 held 20 cycles, then 0.
  - Required: `jogada_pulso` high exactly 1 cycle, in the cycle after edge 7.
  - Required: `jogada_codigo`=4'b0010 and held after release; `db_estado` goes 0→1→0.
- Bounce: botoes[0] toggles 1,0,1,0 every 2 cycles, then holds 1 for 10 cycles.
  - Required: exactly one pulse, starting 7 cycles after the steady level begins; `botoes_estaveis` never toggles during the bounce.
- Multi-press: botoes=4'b0101 held 10 cycles.
  - Required: no `jogada_pulso`; `db_estado`=2; `erro_multiplo` pulses once with the macro defined and stays 0 without it; after release, `db_estado`=0.
- Hold plus extra button: press 4'b1000, then after 10 cycles also press bit 0.
  - Required: one pulse only, `jogada_codigo`=4'b1000; state returns to OCIOSO only after both are released.
- Jogar: jogar held 15 cycles.
  - Required: `jogar_pulso` is a single cycle after edge 7; none on release.
- Reset mid-press: assert reset for 1 cycle while botoes=4'b0100 is held.
  - Required: all outputs 0 in the cycle after reset; a new `jogada_pulso` arrives 7 cycles after reset deasserts.
